uart_boot_loader: RTL

- Sits upstream of the CPU core. It is fed by the UART receiver byte stream and writes a program image into main memory over an AXI4-lite write channel.
- Holds the core (fetch through writeback) in reset via cpu_hold until a complete, checksum-valid image has been stored.
- Image format: magic byte 0xA5, 4-byte little-endian payload length N, N payload bytes, 1 checksum byte.

---
 rtl/uart_boot_loader_pkg.sv | 23 ++
 rtl/uart_boot_loader_rx_skid.sv | 48 ++++
 rtl/uart_boot_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_MAGIC,
    LEN,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } boot_state_t;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;
  localparam logic [7:0] BOOT_ACK   = 8'h4B;
  localparam logic [7:0] BOOT_NAK   = 8'h45;

  // Image checksum is a plain byte sum that wraps modulo 256.
  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_boot_loader_rx_skid.sv
// One-entry byte buffer between the UART receiver strobe and the loader FSM.
// A byte that arrives while the entry is full and not being drained is lost.
module boot_rx_skid (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       consume,
  output logic       buf_valid,
  output logic [7:0] buf_data,
  output logic       overrun
);

  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (consume) valid_d = 1'b0;
    if (in_valid) begin
      if (!valid_q || consume) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
    data_q <= data_d;
  end

  assign buf_valid = valid_q;
  assign buf_data  = data_q;
  assign overrun   = ovr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART-fed boot loader: parses an A5/len/payload/checksum image into memory over AXI4-lite.
// Optional byte echo and ACK/NAK reply enabled by defining UART_BOOT_LOADER_ECHO_EN.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          MAX_BYTES = 65536,
  parameter int          ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [63:0]       wdata,
  output logic [7:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic              rx_overrun
`ifdef UART_BOOT_LOADER_ECHO_EN
  ,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready
`endif
);

  boot_state_t state_q, state_d;

  logic              buf_valid;
  logic [7:0]        buf_data;
  logic              consume;
  logic              echo_stall;

  logic [1:0]        len_cnt_q, len_cnt_d;
  logic [23:0]       len_q, len_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       word_idx_q, word_idx_d;
  logic [2:0]        lane_q, lane_d;
  logic [7:0]        sum_q, sum_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;

  logic [31:0]       len_word;
  logic              word_last;
  logic              b_fire;

  boot_rx_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rx_valid),
    .in_data   (rx_data),
    .consume   (consume),
    .buf_valid (buf_valid),
    .buf_data  (buf_data),
    .overrun   (rx_overrun)
  );

  // Length arrives LSB first, so each new byte lands in the top and shifts down.
  assign len_word  = {buf_data, len_q};
  assign word_last = (lane_q == 3'd7) || (rem_q == 32'd1);
  assign b_fire    = bready_q && bvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_MAGIC;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wdata_q   <= 64'h0;
      wstrb_q   <= 8'h0;
      awaddr_q  <= ADDR_W'(BASE_ADDR);
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awaddr_q  <= awaddr_d;
    end
    len_cnt_q  <= len_cnt_d;
    len_q      <= len_d;
    rem_q      <= rem_d;
    word_idx_q <= word_idx_d;
    lane_q     <= lane_d;
    sum_q      <= sum_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_MAGIC: if (consume && buf_data == BOOT_MAGIC) state_d = LEN;
      LEN: begin
        if (consume && len_cnt_q == 2'd3) begin
          if (len_word > 32'(MAX_BYTES)) state_d = ERROR;
          else if (len_word == 32'd0)    state_d = CHECK;
          else                           state_d = DATA;
        end
      end
      DATA:  if (consume && word_last) state_d = WRITE;
      WRITE: begin
        if (b_fire) begin
          if (bresp != 2'b00)     state_d = ERROR;
          else if (rem_q == 32'd0) state_d = CHECK;
          else                     state_d = DATA;
        end
      end
      CHECK: if (consume) state_d = (buf_data == sum_q) ? DONE : ERROR;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    len_cnt_d  = len_cnt_q;
    len_d      = len_q;
    rem_d      = rem_q;
    word_idx_d = word_idx_q;
    lane_d     = lane_q;
    sum_d      = sum_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awaddr_d   = awaddr_q;
    awvalid_d  = awvalid_q && !awready;
    wvalid_d   = wvalid_q && !wready;
    bready_d   = bready_q && !bvalid;
    // Open the response phase once the last outstanding address/data handshake completes.
    if ((awvalid_q || wvalid_q) && !awvalid_d && !wvalid_d) bready_d = 1'b1;
    case (state_q)
      WAIT_MAGIC: begin
        if (consume) begin
          len_cnt_d = 2'd0;
          sum_d     = 8'h0;
        end
      end
      LEN: begin
        if (consume) begin
          len_d     = len_word[31:8];
          len_cnt_d = len_cnt_q + 2'd1;
          if (len_cnt_q == 2'd3) begin
            rem_d      = len_word;
            word_idx_d = 32'd0;
            lane_d     = 3'd0;
            sum_d      = 8'h0;
            wdata_d    = 64'h0;
            wstrb_d    = 8'h0;
          end
        end
      end
      DATA: begin
        if (consume) begin
          wdata_d[{lane_q, 3'b000} +: 8] = buf_data;
          wstrb_d[lane_q]                = 1'b1;
          sum_d                          = sum8(sum_q, buf_data);
          rem_d                          = rem_q - 32'd1;
          lane_d                         = lane_q + 3'd1;
          if (word_last) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'({word_idx_q, 3'b000});
          end
        end
      end
      WRITE: begin
        if (b_fire && bresp == 2'b00) begin
          word_idx_d = word_idx_q + 32'd1;
          lane_d     = 3'd0;
          wdata_d    = 64'h0;
          wstrb_d    = 8'h0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    consume    = buf_valid && !echo_stall && (state_q != WRITE);
    cpu_hold   = (state_q != DONE);
    load_done  = (state_q == DONE);
    load_error = (state_q == ERROR);
    awaddr     = awaddr_q;
    awvalid    = awvalid_q;
    wdata      = wdata_q;
    wstrb      = wstrb_q;
    wvalid     = wvalid_q;
    bready     = bready_q;
  end

`ifdef UART_BOOT_LOADER_ECHO_EN
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       ack_sent_q, ack_sent_d;

  // Bytes drained in the terminal states are discarded without echo; one ACK/NAK is sent instead.
  always_comb begin
    tx_valid_d = tx_valid_q && !tx_ready;
    tx_data_d  = tx_data_q;
    ack_sent_d = ack_sent_q;
    if (consume && state_q != DONE && state_q != ERROR) begin
      tx_valid_d = 1'b1;
      tx_data_d  = buf_data;
    end else if ((state_q == DONE || state_q == ERROR) && !ack_sent_q && !tx_valid_d) begin
      tx_valid_d = 1'b1;
      tx_data_d  = (state_q == DONE) ? BOOT_ACK : BOOT_NAK;
      ack_sent_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      ack_sent_q <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid_d;
      ack_sent_q <= ack_sent_d;
    end
    tx_data_q <= tx_data_d;
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign echo_stall = tx_valid_q;
`else
  assign echo_stall = 1'b0;
`endif

endmodule
